// File: rtl/sar_adc_scan_if.sv
// Signal bundle between the SAR scan controller and its DAC, comparator, mux and result consumer.
interface sar_adc_scan_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2
);
  logic                start;
  logic                continuous;
  logic [CHANNELS-1:0] ch_mask;
  logic                comp_in;
  logic [WIDTH-1:0]    dac_out;
  logic [CH_W-1:0]     ch_sel;
  logic                busy;
  logic [WIDTH-1:0]    result;
  logic [CH_W-1:0]     result_ch;
  logic                result_valid;
  logic                scan_done;

  modport master (
    input  start, continuous, ch_mask, comp_in,
    output dac_out, ch_sel, busy, result, result_ch, result_valid, scan_done
  );

  modport slave (
    output start, continuous, ch_mask, comp_in,
    input  dac_out, ch_sel, busy, result, result_ch, result_valid, scan_done
  );
endinterface

// File: rtl/sar_adc_scan.sv
// Multi-channel successive-approximation ADC scan controller (external R-2R DAC + comparator + mux).
// Optional per-channel averaging of 2^AVG_LOG2 conversions is enabled by defining SAR_AVG_EN.
module sar_adc_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2,
  parameter int SETTLE   = 2,
  parameter int AVG_LOG2 = 2
) (
  input logic           ADC_Clk,
  input logic           ADC_Rst_n,
  sar_adc_scan_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MUX   = 2'd1;
  localparam logic [1:0] S_TRIAL = 2'd2;
  localparam logic [1:0] S_STORE = 2'd3;

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]    CNT_LAST = SW'(SETTLE - 1);
  localparam logic [WIDTH-1:0] MSB      = WIDTH'(1) << (WIDTH - 1);
  localparam logic [BW-1:0]    TOP_BIT  = BW'(WIDTH - 1);

  if (SETTLE < 1 || (1 << CH_W) < CHANNELS || CHANNELS < 1 || AVG_LOG2 < 0) begin : g_param_check
    $error("sar_adc_scan: illegal parameter combination");
  end

  logic [1:0]          state;
  logic [SW-1:0]       cnt;
  logic [BW-1:0]       bit_idx;
  logic [WIDTH-1:0]    code;
  logic [WIDTH-1:0]    trial_code;
  logic [CHANNELS-1:0] mask;
  logic [CH_W:0]       next_ch;
  logic [CH_W:0]       first_ch;
  logic                conv_last;
  logic [WIDTH-1:0]    final_code;

  // Lowest set channel in m at or above index lo; MSB of the return flags "found".
  function automatic logic [CH_W:0] find_ch(input logic [CHANNELS-1:0] m, input int lo);
    find_ch = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (m[i] && i >= lo) find_ch = {1'b1, CH_W'(i)};
  endfunction

  assign next_ch  = find_ch(mask, int'(bus.ch_sel) + 1);
  assign first_ch = find_ch(bus.ch_mask, 0);

  always_comb begin
    trial_code = code;
    if (!bus.comp_in) trial_code[bit_idx] = 1'b0;
    if (bit_idx != '0) trial_code[bit_idx - BW'(1)] = 1'b1;
  end

`ifdef SAR_AVG_EN
  localparam int RW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int AW = WIDTH + AVG_LOG2;
  logic [RW-1:0] rep;
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;

  assign sum        = acc + AW'(code);
  assign conv_last  = (rep == RW'((1 << AVG_LOG2) - 1));
  assign final_code = WIDTH'(sum >> AVG_LOG2);

  // Accumulator restarts for every channel, so it is cleared on the final STORE.
  always_ff @(posedge ADC_Clk) begin
    if (!ADC_Rst_n) begin
      rep <= '0;
      acc <= '0;
    end else if (state == S_STORE) begin
      if (conv_last) begin
        rep <= '0;
        acc <= '0;
      end else begin
        rep <= rep + RW'(1);
        acc <= sum;
      end
    end
  end
`else
  assign conv_last  = 1'b1;
  assign final_code = code;
`endif

  always_ff @(posedge ADC_Clk) begin
    if (!ADC_Rst_n) begin
      state            <= S_IDLE;
      cnt              <= '0;
      bit_idx          <= '0;
      code             <= '0;
      mask             <= '0;
      bus.dac_out      <= '0;
      bus.ch_sel       <= '0;
      bus.busy         <= 1'b0;
      bus.result       <= '0;
      bus.result_ch    <= '0;
      bus.result_valid <= 1'b0;
      bus.scan_done    <= 1'b0;
    end else begin
      bus.result_valid <= 1'b0;
      bus.scan_done    <= 1'b0;
      case (state)
        S_IDLE: begin
          bus.busy    <= 1'b0;
          bus.dac_out <= '0;
          if ((bus.start || bus.continuous) && bus.ch_mask != '0) begin
            mask       <= bus.ch_mask;
            bus.ch_sel <= first_ch[CH_W-1:0];
            bus.busy   <= 1'b1;
            cnt        <= '0;
            state      <= S_MUX;
          end
        end
        S_MUX: begin
          if (cnt == CNT_LAST) begin
            cnt         <= '0;
            code        <= MSB;
            bus.dac_out <= MSB;
            bit_idx     <= TOP_BIT;
            state       <= S_TRIAL;
          end else begin
            cnt <= cnt + SW'(1);
          end
        end
        S_TRIAL: begin
          // Comparator is sampled on the last settle cycle of each trial.
          if (cnt == CNT_LAST) begin
            cnt  <= '0;
            code <= trial_code;
            if (bit_idx != '0) begin
              bus.dac_out <= trial_code;
              bit_idx     <= bit_idx - BW'(1);
            end else begin
              state <= S_STORE;
            end
          end else begin
            cnt <= cnt + SW'(1);
          end
        end
        default: begin
          bus.dac_out <= '0;
          cnt         <= '0;
          if (!conv_last) begin
            code        <= MSB;
            bus.dac_out <= MSB;
            bit_idx     <= TOP_BIT;
            state       <= S_TRIAL;
          end else begin
            bus.result       <= final_code;
            bus.result_ch    <= bus.ch_sel;
            bus.result_valid <= 1'b1;
            if (next_ch[CH_W]) begin
              bus.ch_sel <= next_ch[CH_W-1:0];
              state      <= S_MUX;
            end else begin
              bus.scan_done <= 1'b1;
              // Continuous rescans take a fresh mask; busy stays high across the rescan.
              if (bus.continuous && bus.ch_mask != '0) begin
                mask       <= bus.ch_mask;
                bus.ch_sel <= first_ch[CH_W-1:0];
                state      <= S_MUX;
              end else begin
                state <= S_IDLE;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
